// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 16;
  localparam int unsigned CNT_W     = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step: shift in a bit, trial-subtract the divisor.
module div_restore_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_unused_rem_msb;

  // The partial remainder is always below the divisor, so its top bit never survives the shift.
  assign w_unused_rem_msb = i_rem[WIDTH];
  assign w_shift          = {i_rem[WIDTH-1:0], i_bit};
  assign w_diff           = w_shift - {1'b0, i_divisor};

  always_comb begin
    o_qbit = 1'b0;
    o_rem  = w_shift;
    if (w_shift >= {1'b0, i_divisor}) begin
      o_qbit = 1'b1;
      o_rem  = w_diff;
    end
  end

endmodule

// File: rtl/iter_divider_16bit.sv
// 16-bit sequential restoring divider, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN to enable two's complement division via i_signed_op.
module iter_divider_16bit
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_signed_op,
  input  logic [DIV_WIDTH-1:0] i_dividend,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [DIV_WIDTH-1:0] o_quotient,
  output logic [DIV_WIDTH-1:0] o_remainder,
  output logic                 o_div_by_zero
);

  div_state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [DIV_WIDTH-1:0] r_q;
  logic [DIV_WIDTH:0]   r_rem;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_quot;
  logic [DIV_WIDTH-1:0] r_remo;
  logic                 r_dbz;

  logic [DIV_WIDTH:0]   w_rem_nxt;
  logic                 w_qbit;
  logic                 w_last;
  logic                 w_div_zero;
  logic [DIV_WIDTH-1:0] w_dividend_mag;
  logic [DIV_WIDTH-1:0] w_divisor_mag;
  logic [DIV_WIDTH-1:0] w_quot_raw;
  logic [DIV_WIDTH-1:0] w_quot_fix;
  logic [DIV_WIDTH-1:0] w_rem_fix;

  div_restore_step #(.WIDTH(DIV_WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_q[DIV_WIDTH-1]),
    .i_divisor (r_div),
    .o_rem     (w_rem_nxt),
    .o_qbit    (w_qbit)
  );

  assign w_last     = (r_cnt == CNT_W'(DIV_WIDTH - 1));
  assign w_div_zero = (i_divisor == '0);
  assign w_quot_raw = {r_q[DIV_WIDTH-2:0], w_qbit};

`ifdef DIVIDER_SIGNED_EN
  logic w_a_neg, w_b_neg;
  logic r_neg_q, r_neg_r;

  assign w_a_neg        = i_signed_op & i_dividend[DIV_WIDTH-1];
  assign w_b_neg        = i_signed_op & i_divisor[DIV_WIDTH-1];
  assign w_dividend_mag = w_a_neg ? -i_dividend : i_dividend;
  assign w_divisor_mag  = w_b_neg ? -i_divisor : i_divisor;
  assign w_quot_fix     = r_neg_q ? -w_quot_raw : w_quot_raw;
  assign w_rem_fix      = r_neg_r ? -w_rem_nxt[DIV_WIDTH-1:0] : w_rem_nxt[DIV_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == S_IDLE && i_start) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end
`else
  logic w_unused_signed_op;

  assign w_unused_signed_op = i_signed_op;
  assign w_dividend_mag     = i_dividend;
  assign w_divisor_mag      = i_divisor;
  assign w_quot_fix         = w_quot_raw;
  assign w_rem_fix          = w_rem_nxt[DIV_WIDTH-1:0];
`endif

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = (r_state != S_IDLE);
    o_done      = (r_state == S_DONE);
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = w_div_zero ? S_DONE : S_CALC;
      S_CALC: if (w_last) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (i_start && w_div_zero) begin
            r_quot <= '1;
            r_remo <= i_dividend;
            r_dbz  <= 1'b1;
          end else if (i_start) begin
            r_q   <= w_dividend_mag;
            r_div <= w_divisor_mag;
            r_rem <= '0;
            r_cnt <= '0;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_quot_raw;
          r_cnt <= r_cnt + CNT_W'(1);
          // Results are taken straight from the final step so they land on the edge entering DONE.
          if (w_last) begin
            r_quot <= w_quot_fix;
            r_remo <= w_rem_fix;
            r_dbz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_quotient    = r_quot;
  assign o_remainder   = r_remo;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_iter_divider_16bit.sv
// Self-checking bench for iter_divider_16bit: scoreboard of expected results, one task per scenario.
module tb_iter_divider_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_signed_op = 1'b0;
  logic [15:0] i_dividend = '0;
  logic [15:0] i_divisor = '0;
  logic        o_busy, o_done, o_div_by_zero;
  logic [15:0] o_quotient, o_remainder;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  iter_divider_16bit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_signed_op   (i_signed_op),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_div_by_zero (o_div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    int   sa, sd;
    logic unused_s;
    unused_s = s;
    sa = 0;
    sd = 0;
    if (b == 16'd0) begin
      e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1;
    end
`ifdef DIVIDER_SIGNED_EN
    else if (s) begin
      sa = int'($signed(a));
      sd = int'($signed(b));
      e.q = 16'(sa / sd); e.r = 16'(sa % sd); e.dbz = 1'b0;
    end
`endif
    else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    i_dividend  = a;
    i_divisor   = b;
    i_signed_op = s;
    i_start     = 1'b1;
    sb.push_back(model(a, b, s));
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt, output bit seen);
    lat = 0; busy_cnt = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (o_busy) busy_cnt++;
      if (o_done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({o_busy, o_done, o_div_by_zero} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {o_busy, o_done, o_div_by_zero});
    end
    n_checks++;
    if ({o_quotient, o_remainder} !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 00000000", {o_quotient, o_remainder});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    int lat, bc; bit seen; exp_t e;
    launch(16'd100, 16'd7, 1'b0);
    wait_done(lat, bc, seen);
    e = sb.pop_front();
    n_checks++;
    if (!seen || lat != 17) begin n_fail++; $display("FAIL unsigned_latency: got %0d expected 17", lat); end
    n_checks++;
    if (bc != 17) begin n_fail++; $display("FAIL unsigned_busy_cycles: got %0d expected 17", bc); end
    n_checks++;
    if ({o_quotient, o_remainder, o_div_by_zero} !== e) begin
      n_fail++; $display("FAIL unsigned_100_7: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                         o_quotient, o_remainder, o_div_by_zero, e.q, e.r, e.dbz);
    end
    @(negedge clk);
    n_checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_quotient !== 16'd14) begin
      n_fail++; $display("FAIL unsigned_hold: got done=%b busy=%b q=%h expected 0 0 000e", o_done, o_busy, o_quotient);
    end
  endtask

  task automatic test_div_zero();
    int lat, bc; bit seen; exp_t e;
    launch(16'd1234, 16'd0, 1'b0);
    wait_done(lat, bc, seen);
    e = sb.pop_front();
    n_checks++;
    if (!seen || lat != 1 || bc != 1) begin
      n_fail++; $display("FAIL dbz_latency: got lat=%0d busy=%0d expected 1 1", lat, bc);
    end
    n_checks++;
    if ({o_quotient, o_remainder, o_div_by_zero} !== e) begin
      n_fail++; $display("FAIL dbz_result: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                         o_quotient, o_remainder, o_div_by_zero, e.q, e.r, e.dbz);
    end
  endtask

  task automatic test_busy_ignore();
    int lat, bc; bit seen; exp_t e;
    launch(16'hFFFF, 16'd1, 1'b0);
    lat = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (o_done) seen = 1'b1;
      else begin
        i_start    = 1'b1;
        i_dividend = 16'($urandom);
        i_divisor  = 16'($urandom_range(0, 300));
      end
    end
    e = sb.pop_front();
    n_checks++;
    if (!seen || lat != 17) begin n_fail++; $display("FAIL busy_ignore_latency: got %0d expected 17", lat); end
    n_checks++;
    if ({o_quotient, o_remainder, o_div_by_zero} !== e) begin
      n_fail++; $display("FAIL busy_ignore_result: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                         o_quotient, o_remainder, o_div_by_zero, e.q, e.r, e.dbz);
    end
    i_dividend = 16'd50; i_divisor = 16'd5; i_start = 1'b1;
    sb.push_back(model(16'd50, 16'd5, 1'b0));
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL busy_ignore_no_queue: got busy=%b done=%b expected 0 0", o_busy, o_done);
    end
    @(posedge clk);
    #1 i_start = 1'b0;
    wait_done(lat, bc, seen);
    e = sb.pop_front();
    n_checks++;
    if (!seen || lat != 17 || {o_quotient, o_remainder, o_div_by_zero} !== e) begin
      n_fail++; $display("FAIL busy_ignore_next_op: got lat=%0d q=%h r=%h expected 17 q=%h r=%h",
                         lat, o_quotient, o_remainder, e.q, e.r);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc; bit seen; exp_t e;
    launch(16'd1000, 16'd3, 1'b0);
    repeat (8) @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid_busy: got %b expected 1", o_busy); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_busy, o_done, o_div_by_zero, o_quotient, o_remainder} !== 35'h0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got busy=%b done=%b z=%b q=%h r=%h expected all 0",
                         o_busy, o_done, o_div_by_zero, o_quotient, o_remainder);
    end
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    launch(16'd9, 16'd3, 1'b0);
    wait_done(lat, bc, seen);
    e = sb.pop_front();
    n_checks++;
    if (!seen || lat != 17 || {o_quotient, o_remainder, o_div_by_zero} !== e) begin
      n_fail++; $display("FAIL reset_mid_recover: got lat=%0d q=%h r=%h expected 17 q=%h r=%h",
                         lat, o_quotient, o_remainder, e.q, e.r);
    end
  endtask

  task automatic test_patterns();
    logic [15:0] ta[10];
    logic [15:0] tb_[10];
    int lat, bc; bit seen; exp_t e;
    ta  = '{16'd0, 16'd5, 16'hFFFF, 16'd3, 16'hFFFF, 16'h8000, 0, 0, 0, 0};
    tb_ = '{16'd5, 16'hFFFF, 16'hFFFF, 16'd5, 16'd2, 16'd1, 0, 0, 0, 0};
    for (int i = 6; i < 10; i++) begin
      ta[i]  = 16'($urandom);
      tb_[i] = 16'($urandom_range(1, 65535));
    end
    for (int i = 0; i < 10; i++) begin
      launch(ta[i], tb_[i], 1'b0);
      wait_done(lat, bc, seen);
      e = sb.pop_front();
      n_checks++;
      if (!seen || lat != 17 || {o_quotient, o_remainder, o_div_by_zero} !== e) begin
        n_fail++; $display("FAIL pattern_%0d %h/%h: got lat=%0d q=%h r=%h z=%b expected 17 q=%h r=%h z=%b",
                           i, ta[i], tb_[i], lat, o_quotient, o_remainder, o_div_by_zero, e.q, e.r, e.dbz);
      end
    end
  endtask

  task automatic test_signed_mode();
    logic [15:0] ta[3];
    logic [15:0] tb_[3];
    logic        ts[3];
    int lat, bc; bit seen; exp_t e;
`ifdef DIVIDER_SIGNED_EN
    ta = '{16'hFFF9, 16'h8000, 16'hFFF9}; tb_ = '{16'd2, 16'hFFFF, 16'd2}; ts = '{1'b1, 1'b1, 1'b0};
`else
    ta = '{16'hFFF9, 16'h8000, 16'd100}; tb_ = '{16'd2, 16'hFFFF, 16'hFFF9}; ts = '{1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 3; i++) begin
      launch(ta[i], tb_[i], ts[i]);
      wait_done(lat, bc, seen);
      e = sb.pop_front();
      n_checks++;
      if (!seen || lat != 17 || {o_quotient, o_remainder, o_div_by_zero} !== e) begin
        n_fail++; $display("FAIL signed_mode_%0d %h/%h s=%b: got lat=%0d q=%h r=%h expected 17 q=%h r=%h",
                           i, ta[i], tb_[i], ts[i], lat, o_quotient, o_remainder, e.q, e.r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
    test_patterns();
    test_signed_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iter_divider_16bit.md
# iter_divider_16bit

Sequential 16-bit restoring divider: the inverse counterpart of the combinational 16-bit multiplier in the execute stage, used by DIV/REM instructions. It accepts a dividend/divisor pair on a start pulse and retires one quotient bit per clock. It presents quotient and remainder with a one-cycle done pulse. The pipeline stalls on busy.

## Interface
- WIDTH, 16: operand, quotient and remainder width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- signed_op  in  1  treat operands as two's complement (effective only with the macro below).
- dividend  in  WIDTH  numerator, sampled on the accepting edge.
- divisor  in  WIDTH  denominator, sampled on the accepting edge.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; results valid in this cycle.
- quotient  out  WIDTH  held from done until the next accepted start.
- remainder  out  WIDTH  held from done until the next accepted start.
- div_by_zero  out  1  valid with done; held like quotient.

## Operation
- FSM states are IDLE, CALC and DONE.
- IDLE, start=1, divisor≠0: latch operands (magnitudes if signed), clear partial remainder (WIDTH+1 bits), count=0, go to CALC.
- IDLE, start=1, divisor=0: go straight to DONE.
  - quotient = all ones.
  - remainder = dividend.
  - div_by_zero = 1.
  - Identical for signed and unsigned operation.
- CALC, one step per edge:
  - r' = {r[WIDTH-1:0], q_msb}.
  - q shifts left.
  - If r' ≥ {1'b0, divisor}: r = r' − divisor and q LSB = 1. Otherwise r = r' and q LSB = 0.
  - After WIDTH steps, register the results and go to DONE.
- DONE: done=1 for this cycle only, then go to IDLE on the next edge.
- start while busy (CALC or DONE) is ignored, and no request is queued.
- Operands may change freely after the accepting edge.
- Reset (asynchronous, any state, including mid-CALC): state=IDLE and all counters and data registers cleared. Outputs go to busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. A partial result is discarded.

## Timing
- Normal division: accept at edge k, iterate on edges k+1..k+WIDTH, so done is high in the cycle after edge k+WIDTH. Latency is WIDTH+1 = 17 cycles, and busy is high for 17 cycles.
- Divide-by-zero: done is high in the cycle after the accepting edge (latency 1), with busy high for that one cycle.
- Minimum start-to-start spacing is latency + 1 (the first IDLE cycle after DONE accepts).
- The results registers update only on the edge entering DONE.

## Configuration
- DIVIDER_SIGNED_EN defined:
  - signed_op=1 divides magnitudes, then negates quotient if the operand signs differ; remainder takes the dividend's sign.
  - Sign fix-up happens on the edge entering DONE and adds no cycles.
  - Overflow case (most-negative / −1): quotient = most-negative, remainder = 0, via the normal 17-cycle path.
- Undefined: signed_op is ignored, all operation is unsigned, and no sign logic is synthesised.

## Structure
- Shared package div_pkg holds:
  - the FSM state typedef (IDLE/CALC/DONE);
  - the DIV_WIDTH=16 constant;
  - the step-count width, clog2(WIDTH+1).
- One sub-module, div_restore_step: purely combinational single restoring step. Input is the partial remainder, incoming bit and divisor; outputs are the next remainder and the quotient bit.

## Test plan
- Unsigned 100/7: start for 1 cycle -> done exactly 17 cycles later, quotient=14, remainder=2, div_by_zero=0, busy high for 17 cycles.
- Divide-by-zero 1234/0 -> done 1 cycle after accept, quotient=0xFFFF, remainder=1234, div_by_zero=1.
- start asserted on every cycle during CALC and DONE with different operands -> the first result (0xFFFF/1 -> quotient 0xFFFF, remainder 0) is unaffected. The next op is accepted only in the following IDLE cycle.
- rst_n low at cycle 8 of a CALC -> all outputs 0 immediately; after release, 9/3 completes correctly (quotient 3, remainder 0).
- With DIVIDER_SIGNED_EN:
  - −7/2 -> quotient 0xFFFD, remainder 0xFFFF.
  - 0x8000/0xFFFF -> quotient 0x8000, remainder 0.
  - signed_op=0 with 0xFFF9/2 -> quotient 0x7FFC, remainder 1.
- Without DIVIDER_SIGNED_EN: signed_op=1 with 0xFFF9/2 -> quotient 0x7FFC, remainder 1.
